// File: rtl/increment_sweep_if.sv
// rtl/increment_sweep_if.sv - control, result and checker-operand bundle for increment_sweep
interface increment_sweep_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    // sweep launch and configuration
    logic             start;
    logic [W-1:0]     cfg_base;
    logic [W-1:0]     cfg_stride;
    logic [CNT_W-1:0] cfg_count;
    logic             cfg_stop_on_fail;

    // checker operand and its mismatch flag
    logic [W-1:0]     a;
    logic             fail;

    // handshake and results
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic             first_fail_vld;
    logic [W-1:0]     first_fail_a;
    logic             pass;

    // controller / bench side: launches sweeps, supplies the checker verdict
    modport master (
        output start,
        output cfg_base,
        output cfg_stride,
        output cfg_count,
        output cfg_stop_on_fail,
        output fail,
        input  a,
        input  busy,
        input  done,
        input  err_cnt,
        input  first_fail_vld,
        input  first_fail_a,
        input  pass
    );

    // sweep engine side
    modport slave (
        input  start,
        input  cfg_base,
        input  cfg_stride,
        input  cfg_count,
        input  cfg_stop_on_fail,
        input  fail,
        output a,
        output busy,
        output done,
        output err_cnt,
        output first_fail_vld,
        output first_fail_a,
        output pass
    );
endinterface

// File: rtl/increment_sweep.sv
// rtl/increment_sweep.sv - operand sweep driver and mismatch collector around the increment checker
module increment_sweep #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    increment_sweep_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     stride_q, stride_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             first_fail_vld_q, first_fail_vld_d;
    logic [W-1:0]     first_fail_a_q, first_fail_a_d;
    logic             pass_q, pass_d;

    // next-state and datapath updates; everything holds unless a state says otherwise
    always_comb begin
        state_d          = state_q;
        a_d              = a_q;
        stride_d         = stride_q;
        stop_d           = stop_q;
        remaining_d      = remaining_q;
        err_cnt_d        = err_cnt_q;
        first_fail_vld_d = first_fail_vld_q;
        first_fail_a_d   = first_fail_a_q;
        pass_d           = pass_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // configuration is captured here and only here
                    stride_d         = bus.cfg_stride;
                    stop_d           = bus.cfg_stop_on_fail;
                    a_d              = bus.cfg_base;
                    remaining_d      = bus.cfg_count;
                    err_cnt_d        = '0;
                    first_fail_vld_d = 1'b0;
                    first_fail_a_d   = '0;
                    pass_d           = 1'b0;
                    // an empty sweep skips RUN and reports a clean pass
                    state_d          = (bus.cfg_count != '0) ? S_RUN : S_DONE;
                end
            end

            S_RUN: begin
                // fail is the checker's verdict on the a currently on the bus
                if (bus.fail) begin
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = err_cnt_q + CNT_ONE;
                    end
                    if (!first_fail_vld_q) begin
                        first_fail_vld_d = 1'b1;
                        first_fail_a_d   = a_q;
                    end
                end
                a_d         = a_q + stride_q;
                remaining_d = remaining_q - CNT_ONE;
                if ((remaining_q == CNT_ONE) || (bus.fail && stop_q)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // err_cnt already includes the last RUN cycle's update
                pass_d  = (err_cnt_q == '0);
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            a_q              <= '0;
            stride_q         <= '0;
            stop_q           <= 1'b0;
            remaining_q      <= '0;
            err_cnt_q        <= '0;
            first_fail_vld_q <= 1'b0;
            first_fail_a_q   <= '0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            a_q              <= a_d;
            stride_q         <= stride_d;
            stop_q           <= stop_d;
            remaining_q      <= remaining_d;
            err_cnt_q        <= err_cnt_d;
            first_fail_vld_q <= first_fail_vld_d;
            first_fail_a_q   <= first_fail_a_d;
            pass_q           <= pass_d;
        end
    end

    // outputs; busy/done decode straight from the registered state so reset clears them at once
    always_comb begin
        bus.a              = a_q;
        bus.busy           = (state_q != S_IDLE);
        bus.done           = (state_q == S_DONE);
        bus.err_cnt        = err_cnt_q;
        bus.first_fail_vld = first_fail_vld_q;
        bus.first_fail_a   = first_fail_a_q;
        bus.pass           = pass_q;
    end

endmodule

// File: tb/tb_increment_sweep.sv
// tb/tb_increment_sweep.sv - directed table-driven bench for increment_sweep
module tb_increment_sweep;

    logic       clk;
    logic       rst;
    logic [1:0] fail_mode;
    int         n_tests;
    int         n_fail;

    increment_sweep_if #(.W(32), .CNT_W(16)) bus_if ();

    increment_sweep #(.W(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stand-in checker: 0 never fails, 1 fails on a==5/7, 2 fails on a==22, 3 always fails
    assign bus_if.fail = ((fail_mode == 2'd1) && ((bus_if.a == 32'd5) || (bus_if.a == 32'd7))) ||
                         ((fail_mode == 2'd2) && (bus_if.a == 32'd22)) ||
                         (fail_mode == 2'd3);

    typedef struct {
        logic [31:0] base;
        logic [31:0] stride;
        logic [15:0] count;
        logic        stop;
        logic [1:0]  fmode;
        logic        poke;
        int          exp_cycles;
        logic [15:0] exp_err;
        logic        exp_ffv;
        logic [31:0] exp_ffa;
        logic        exp_pass;
        logic [31:0] exp_a;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // launch one sweep from IDLE, check a per RUN cycle, the done timing and the results
    task automatic run_sweep(input vec_t v, input int idx);
        int          cyc;
        int          a_err;
        logic [31:0] exp_run_a;
        string       tag;
        tag = $sformatf("v%0d", idx);
        fail_mode = v.fmode;
        @(negedge clk);
        bus_if.start            = 1'b1;
        bus_if.cfg_base         = v.base;
        bus_if.cfg_stride       = v.stride;
        bus_if.cfg_count        = v.count;
        bus_if.cfg_stop_on_fail = v.stop;
        @(negedge clk);
        bus_if.start = 1'b0;
        cyc       = 1;
        a_err     = 0;
        exp_run_a = v.base;
        while (!bus_if.done && cyc < 300) begin
            if (bus_if.a !== exp_run_a || bus_if.busy !== 1'b1) a_err++;
            exp_run_a = exp_run_a + v.stride;
            // optional stray start with different configuration while busy
            bus_if.start = v.poke && (cyc == 2);
            if (v.poke && cyc == 2) begin
                bus_if.cfg_base         = 32'h0;
                bus_if.cfg_stride       = 32'd7;
                bus_if.cfg_count        = 16'd0;
                bus_if.cfg_stop_on_fail = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        bus_if.start = 1'b0;
        check({tag, "_run_a_seq"}, a_err, 0);
        check({tag, "_done_cycle"}, cyc, v.exp_cycles);
        check({tag, "_busy_in_done"}, bus_if.busy, 1'b1);
        @(negedge clk);
        check({tag, "_done_one_shot"}, bus_if.done, 1'b0);
        check({tag, "_busy_after"}, bus_if.busy, 1'b0);
        check({tag, "_err_cnt"}, bus_if.err_cnt, v.exp_err);
        check({tag, "_ffv"}, bus_if.first_fail_vld, v.exp_ffv);
        check({tag, "_ffa"}, bus_if.first_fail_a, v.exp_ffa);
        check({tag, "_pass"}, bus_if.pass, v.exp_pass);
        check({tag, "_final_a"}, bus_if.a, v.exp_a);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_a"}, bus_if.a, 32'h0);
        check({tag, "_busy"}, bus_if.busy, 1'b0);
        check({tag, "_done"}, bus_if.done, 1'b0);
        check({tag, "_err"}, bus_if.err_cnt, 16'h0);
        check({tag, "_ffv"}, bus_if.first_fail_vld, 1'b0);
        check({tag, "_ffa"}, bus_if.first_fail_a, 32'h0);
        check({tag, "_pass"}, bus_if.pass, 1'b0);
    endtask

    initial begin
        int   saw_done;
        vec_t v3;
        n_tests = 0;
        n_fail  = 0;
        fail_mode = 2'd0;
        bus_if.start            = 1'b0;
        bus_if.cfg_base         = 32'h0;
        bus_if.cfg_stride       = 32'h0;
        bus_if.cfg_count        = 16'h0;
        bus_if.cfg_stop_on_fail = 1'b0;

        //            base          stride  count  stop fm   poke cyc err    ffv ffa    pass final a
        vecs[0] = '{32'h0,        32'd1, 16'd4,  1'b0, 2'd0, 1'b0, 5,  16'd0, 1'b0, 32'd0,  1'b1, 32'd4};
        vecs[1] = '{32'hFFFF_FFFE,32'd1, 16'd4,  1'b0, 2'd0, 1'b0, 5,  16'd0, 1'b0, 32'd0,  1'b1, 32'd2};
        vecs[2] = '{32'h0,        32'd1, 16'd10, 1'b0, 2'd1, 1'b0, 11, 16'd2, 1'b1, 32'd5,  1'b0, 32'd10};
        vecs[3] = '{32'h0,        32'd1, 16'd10, 1'b1, 2'd1, 1'b0, 7,  16'd1, 1'b1, 32'd5,  1'b0, 32'd6};
        vecs[4] = '{32'h1234,     32'd1, 16'd0,  1'b0, 2'd0, 1'b0, 1,  16'd0, 1'b0, 32'd0,  1'b1, 32'h1234};
        vecs[5] = '{32'd10,       32'd3, 16'd5,  1'b1, 2'd2, 1'b1, 6,  16'd1, 1'b1, 32'd22, 1'b0, 32'd25};
        vecs[6] = '{32'd7,        32'd2, 16'd3,  1'b0, 2'd3, 1'b1, 4,  16'd3, 1'b1, 32'd7,  1'b0, 32'd13};
        vecs[7] = '{32'd100,      32'd0, 16'd2,  1'b0, 2'd0, 1'b1, 3,  16'd0, 1'b0, 32'd0,  1'b1, 32'd100};

        // reset values
        rst = 1'b1;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_sweep(vecs[i], i);
        end

        // asynchronous reset in the middle of a long failing sweep
        fail_mode = 2'd3;
        @(negedge clk);
        bus_if.start            = 1'b1;
        bus_if.cfg_base         = 32'd40;
        bus_if.cfg_stride       = 32'd1;
        bus_if.cfg_count        = 16'd100;
        bus_if.cfg_stop_on_fail = 1'b0;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_pre_busy", bus_if.busy, 1'b1);
        check("midrst_pre_err", bus_if.err_cnt, 16'd5);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        saw_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_if.done) saw_done++;
        end
        check("midrst_no_done", saw_done, 0);
        rst = 1'b0;

        // a clean sweep right after the interrupted one
        v3 = '{32'd50, 32'd1, 16'd3, 1'b0, 2'd0, 1'b0, 4, 16'd0, 1'b0, 32'd0, 1'b1, 32'd53};
        run_sweep(v3, 99);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/increment_sweep.md
Name: increment_sweep

Overview:
- Sequential stimulus/checker stage wrapped around the combinational increment equivalence checker.
- Sweeps an operand sequence onto the checker's A input, one operand per cycle, and samples its fail output in the same cycle.
- Accumulates a saturating mismatch count and captures the first failing operand.
- Reports pass/fail to the bench or control logic through a start/busy/done handshake.

Parameters:
- W, 32, operand width; must equal the checker's W.
- CNT_W, 16, width of the operand-count and error-count fields.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch a sweep; honoured only in IDLE.
- cfg_base  in  W  first operand.
- cfg_stride  in  W  operand increment per step.
- cfg_count  in  CNT_W  number of operands to check.
- cfg_stop_on_fail  in  1  end the sweep at the first mismatch.
- a  out  W  operand driven to the checker's A input; registered.
- fail  in  1  checker mismatch flag; combinational function of a.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at sweep completion.
- err_cnt  out  CNT_W  mismatches seen; saturates at all-ones.
- first_fail_vld  out  1  at least one mismatch recorded.
- first_fail_a  out  W  operand of the first mismatch.
- pass  out  1  high when the last completed sweep had err_cnt == 0.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, a=0, busy=0, done=0, err_cnt=0, first_fail_vld=0, first_fail_a=0, pass=0, internal remaining=0, stride register=0, stop register=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 with cfg_count != 0: latch stride and stop_on_fail, a<=cfg_base, remaining<=cfg_count, clear err_cnt, first_fail_vld, first_fail_a and pass, go to RUN.
  - start=1 with cfg_count == 0: clear results and go directly to DONE; the sweep then reports pass=1.
  - Otherwise hold all state.
- RUN, every cycle:
  - Sample fail for the current a.
  - On fail=1: err_cnt<=err_cnt+1 unless already all-ones. If first_fail_vld=0, set first_fail_vld=1 and first_fail_a<=a.
  - Advance a<=a+stride, modulo 2^W, with silent wrap-around.
  - remaining<=remaining-1.
  - Go to DONE when remaining==1, or when fail=1 and stop_on_fail=1.
- DONE:
  - Assert done for exactly one cycle.
  - pass<=(err_cnt==0), using the final count including the last RUN cycle's update.
  - Go to IDLE.
- Latency: a sweep of N operands without early stop takes N RUN cycles plus one DONE cycle. done rises N+1 cycles after the start cycle.
- a holds its last value (base + N*stride) after the sweep. Results hold until the next accepted start.
- start while busy=1 is ignored and has no effect on the configuration in flight.
- cfg_* inputs are sampled only on the start cycle; later changes have no effect.
- Simultaneous fail and final operand: the mismatch is counted and captured before DONE.
- Reset mid-sweep returns immediately to reset values; done is not pulsed.
- remaining is CNT_W wide; cfg_count=all-ones runs the full 2^CNT_W-1 operands.

Test Plan:
- base=0, stride=1, count=4, fail tied 0 -> a=0,1,2,3 on the four RUN cycles; done on the 5th cycle after start; err_cnt=0, pass=1, first_fail_vld=0.
- base=0xFFFF_FFFE, stride=1, count=4 -> a=FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001; no error; final a=2.
- base=0, stride=1, count=10, fail forced when a==5 or a==7, stop_on_fail=0 -> err_cnt=2, first_fail_a=5, pass=0, done after 10 RUN cycles.
- Same stimulus with stop_on_fail=1 -> sweep ends after the a=5 cycle (6 RUN cycles); err_cnt=1, first_fail_a=5.
- count=0 with start -> DONE the next cycle, done pulses once, pass=1; start pulsed during busy in any sweep -> ignored.
- Assert rst during RUN of count=100 -> all outputs return to reset values asynchronously; no done pulse; a following sweep with count=3 completes normally.
